// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 Set 2 key decoder: scan codes, key indices and FSM encoding.
package ps2_key_pkg;

    localparam int NUM_KEYS = 7;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_SPACE = 4;
    localparam int KEY_ENTER = 5;
    localparam int KEY_ESC   = 6;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // Arrow keys exist only as extended codes; their plain codes are keypad keys and stay unmapped.
    function automatic logic key_hit(input int idx, input logic ext, input logic [7:0] code);
        case (idx)
            KEY_UP:    key_hit = ext && (code == SC_UP);
            KEY_DOWN:  key_hit = ext && (code == SC_DOWN);
            KEY_LEFT:  key_hit = ext && (code == SC_LEFT);
            KEY_RIGHT: key_hit = ext && (code == SC_RIGHT);
            KEY_SPACE: key_hit = !ext && (code == SC_SPACE);
            KEY_ENTER: key_hit = (code == SC_ENTER);
            KEY_ESC:   key_hit = !ext && (code == SC_ESC);
            default:   key_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Counts idle cycles while a prefix is pending; pulses expire on the last allowed cycle.
module ps2_prefix_timer #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LAST)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // A byte on the expiry cycle clears the count, so the byte wins over the timeout.
    assign expire = enable && !clear && (count_reg == LAST);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scan-code decoder producing held levels and press/release pulses for game keys.
// Optional PS2_TYPEMATIC_FILTER_EN suppresses press pulses from typematic auto-repeat.
import ps2_key_pkg::*;

module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                kb_err
);

    logic [1:0] state_reg;
    logic [1:0] state_next;
    key_vec_t   held_reg;
    key_vec_t   held_next;
    key_vec_t   press_reg;
    key_vec_t   press_next;
    key_vec_t   release_reg;
    key_vec_t   release_next;
    logic       err_reg;
    logic       err_next;

    key_vec_t   hit;
    key_vec_t   press_mask;
    logic       is_ext;
    logic       is_brk;
    logic       timer_expire;

    assign is_ext = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
    assign is_brk = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            assign hit[gi] = key_hit(gi, is_ext, rx_data);
        end
    endgenerate

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign press_mask = hit & ~held_reg;
`else
    assign press_mask = hit;
`endif

    ps2_prefix_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid || (state_reg == ST_IDLE)),
        .enable (state_reg != ST_IDLE),
        .expire (timer_expire)
    );

    always_comb begin
        state_next   = state_reg;
        held_next    = held_reg;
        press_next   = '0;
        release_next = '0;
        err_next     = 1'b0;
        if (rx_valid) begin
            case (rx_data)
                SC_ERR0, SC_ERR1: begin
                    err_next   = 1'b1;
                    held_next  = '0;
                    state_next = ST_IDLE;
                end
                SC_BAT_OK: begin
                    held_next  = '0;
                    state_next = ST_IDLE;
                end
                SC_ACK, SC_RESEND, SC_ECHO: begin
                end
                // Prefixes accumulate: E0 and F0 in either order lead to the extended-break state.
                SC_EXT: state_next = is_brk ? ST_EXT_BRK : ST_EXT;
                SC_BRK: state_next = is_ext ? ST_EXT_BRK : ST_BRK;
                default: begin
                    state_next = ST_IDLE;
                    if (is_brk) begin
                        held_next    = held_reg & ~hit;
                        release_next = hit;
                    end else begin
                        held_next  = held_reg | hit;
                        press_next = press_mask;
                    end
                end
            endcase
        end else if (timer_expire) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            held_reg    <= '0;
            press_reg   <= '0;
            release_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            held_reg    <= held_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            err_reg     <= err_next;
        end
    end

    assign key_held    = held_reg;
    assign key_press   = press_reg;
    assign key_release = release_reg;
    assign kb_err      = err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: vector table, directed corner cases, random bytes vs model.
module tb_ps2_key_decoder;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [6:0] key_held;
    logic [6:0] key_press;
    logic [6:0] key_release;
    logic       kb_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .key_held    (key_held),
        .key_press   (key_press),
        .key_release (key_release),
        .kb_err      (kb_err)
    );

    // Reference model: pending-prefix flags, idle counter and key levels.
    bit       m_ext;
    bit       m_brk;
    int       m_idle;
    bit [6:0] m_held;
    bit [6:0] m_press;
    bit [6:0] m_rel;
    bit       m_err;
    bit       verbose;

    function automatic int key_index(input bit ext, input logic [7:0] code);
        if (code == 8'h5A) return 5;
        if (ext) begin
            case (code)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (code)
            8'h29: return 4;
            8'h76: return 6;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0;
        m_held = '0; m_press = '0; m_rel = '0; m_err = 0;
    endtask

    task automatic model_cycle(input logic v, input logic [7:0] d);
        int k;
        m_press = '0; m_rel = '0; m_err = 0;
        if (!v) begin
            if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle >= T) begin
                    m_ext = 0;
                    m_brk = 0;
                end
            end
            return;
        end
        m_idle = 0;
        if (d == 8'h00 || d == 8'hFF) begin
            m_err = 1; m_held = '0; m_ext = 0; m_brk = 0;
        end else if (d == 8'hAA) begin
            m_held = '0; m_ext = 0; m_brk = 0;
        end else if (d == 8'hFA || d == 8'hFE || d == 8'hEE) begin
            // acknowledgements leave everything as it was
        end else if (d == 8'hE0) begin
            m_ext = 1;
        end else if (d == 8'hF0) begin
            m_brk = 1;
        end else begin
            k = key_index(m_ext, d);
            if (k >= 0) begin
                if (m_brk) begin
                    m_held[k] = 0;
                    m_rel[k]  = 1;
                end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                    m_press[k] = !m_held[k];
`else
                    m_press[k] = 1;
`endif
                    m_held[k] = 1;
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        model_cycle(v, d);
        check("held", {25'd0, key_held}, {25'd0, m_held});
        check("press", {25'd0, key_press}, {25'd0, m_press});
        check("release", {25'd0, key_release}, {25'd0, m_rel});
        check("kb_err", {31'd0, kb_err}, {31'd0, m_err});
        if (v && verbose)
            $display("byte %02h held %02h press %02h rel %02h err %0b",
                     d, key_held, key_press, key_release, kb_err);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {10'd0, key_held, key_press, key_release, kb_err}, 32'd0);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [6:0] held;
        logic [6:0] press;
        logic [6:0] rel;
        logic       err;
    } vec_t;

    vec_t tbl[13];

    logic [7:0] pool[20];

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        int r;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        verbose  = 1'b1;

        tbl[0]  = '{1'b1, 8'hE0, 7'h00, 7'h00, 7'h00, 1'b0};
        tbl[1]  = '{1'b1, 8'h75, 7'h01, 7'h01, 7'h00, 1'b0};
        tbl[2]  = '{1'b1, 8'hE0, 7'h01, 7'h00, 7'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'hF0, 7'h01, 7'h00, 7'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h75, 7'h00, 7'h00, 7'h01, 1'b0};
        tbl[5]  = '{1'b0, 8'h75, 7'h00, 7'h00, 7'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h75, 7'h00, 7'h00, 7'h00, 1'b0};
        tbl[7]  = '{1'b1, 8'h76, 7'h40, 7'h40, 7'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'hF0, 7'h40, 7'h00, 7'h00, 1'b0};
        tbl[9]  = '{1'b1, 8'h29, 7'h40, 7'h00, 7'h10, 1'b0};
        tbl[10] = '{1'b1, 8'hF0, 7'h40, 7'h00, 7'h00, 1'b0};
        tbl[11] = '{1'b1, 8'h76, 7'h00, 7'h00, 7'h40, 1'b0};
        tbl[12] = '{1'b1, 8'hFA, 7'h00, 7'h00, 7'h00, 1'b0};

        pool = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h29, 8'h5A, 8'h76, 8'hFA, 8'hFE, 8'hEE, 8'hAA, 8'h00, 8'hFF, 8'h11};

        do_reset();

        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_held", i), {25'd0, key_held}, {25'd0, tbl[i].held});
            check($sformatf("tbl%0d_press", i), {25'd0, key_press}, {25'd0, tbl[i].press});
            check($sformatf("tbl%0d_release", i), {25'd0, key_release}, {25'd0, tbl[i].rel});
            check($sformatf("tbl%0d_kb_err", i), {31'd0, kb_err}, {31'd0, tbl[i].err});
        end

        // Enter through both encodings: auto-repeat press counting
        np = 0;
        tick(1, 8'h5A); np += int'(key_press[5]);
        tick(1, 8'hE0);
        tick(1, 8'h5A); np += int'(key_press[5]);
        check("enter_held", {31'd0, key_held[5]}, 32'd1);
        tick(1, 8'hF0);
        tick(1, 8'h5A);
        check("enter_release", {31'd0, key_release[5]}, 32'd1);
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("enter_press_count", np, 32'd1);
`else
        check("enter_press_count", np, 32'd2);
`endif

        // Byte on the expiry cycle is still extended; one cycle later it is not
        tick(1, 8'hE0);
        repeat (T - 1) tick(0, 8'($urandom));
        tick(1, 8'h75);
        check("expiry_byte_wins", {31'd0, key_held[0]}, 32'd1);
        tick(1, 8'hE0); tick(1, 8'hF0); tick(1, 8'h75);
        tick(1, 8'hE0);
        repeat (T) tick(0, 8'($urandom));
        tick(1, 8'h29);
        check("timeout_normal_make", {31'd0, key_held[4]}, 32'd1);
        tick(1, 8'hE0);
        repeat (T) tick(0, 8'($urandom));
        tick(1, 8'h75);
        check("timeout_keypad_ignored", {31'd0, key_held[0]}, 32'd0);

        // Error and self-test codes clear without release pulses
        tick(1, 8'hE0); tick(1, 8'h75); tick(1, 8'h29);
        tick(1, 8'hFF);
        check("ff_err", {31'd0, kb_err}, 32'd1);
        check("ff_held", {25'd0, key_held}, 32'd0);
        check("ff_release", {25'd0, key_release}, 32'd0);
        tick(1, 8'hE0); tick(1, 8'h75); tick(1, 8'h29);
        tick(1, 8'hAA);
        check("aa_err", {31'd0, kb_err}, 32'd0);
        check("aa_held", {25'd0, key_held}, 32'd0);
        check("aa_release", {25'd0, key_release}, 32'd0);

        // Reset in the middle of E0 F0
        tick(1, 8'hE0); tick(1, 8'h75); tick(1, 8'hE0); tick(1, 8'hF0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_held", {25'd0, key_held}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(1, 8'h74);
        check("post_reset_74", {25'd0, key_held}, 32'd0);
        tick(1, 8'h29);
        check("post_reset_idle", {31'd0, key_held[4]}, 32'd1);

        // Back-to-back strobes
        tick(1, 8'hF0);
        tick(1, 8'h76);
        check("b2b_release", {31'd0, key_release[6]}, 32'd1);
        tick(1, 8'h76);
        check("b2b_press", {31'd0, key_press[6]}, 32'd1);
        check("b2b_held", {31'd0, key_held[6]}, 32'd1);

        // Random byte stream against the model
        verbose = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25) begin
                tick(0, 8'($urandom));
            end else if (r < 28) begin
                repeat ($urandom_range(T - 2, T + 3)) tick(0, 8'($urandom));
            end else begin
                r = $urandom_range(0, 19);
                if (r == 19) tick(1, 8'($urandom));
                else if ((r == 17 || r == 18) && $urandom_range(0, 3) != 0) tick(1, 8'h29);
                else tick(1, pool[r]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the PS/2 scan-code byte stream (Set 2) from the keyboard receiver into per-key held levels and single-cycle press/release pulses for the game keys. Sits between the PS/2 byte receiver and `pixel_gen`/game logic, replacing raw button inputs (`up`, `down`, `left`, `right`, `space`, `enter`) with keyboard-driven equivalents. Handles `E0` extended prefixes, `F0` break prefixes, prefix timeout and keyboard error/self-test codes.

## Interface
- `TIMEOUT_CYCLES`, 2_000_000, cycles allowed between a prefix byte and its follow-on byte (20 ms at 100 MHz).
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `rx_data`  in  8  received scan-code byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` valid this cycle.
- `key_held`  out  7  level per key, 1 while pressed; index 0 up, 1 down, 2 left, 3 right, 4 space, 5 enter, 6 esc.
- `key_press`  out  7  one-cycle pulse on make, same indexing.
- `key_release`  out  7  one-cycle pulse on break, same indexing.
- `kb_err`  out  1  one-cycle pulse on keyboard error code (`00` or `FF`).

## Operation
- Key map: up `E0 75`, down `E0 72`, left `E0 6B`, right `E0 74`, space `29`, enter `5A` or `E0 5A`, esc `76`. Non-extended `75/72/6B/74` (keypad) and all other codes are ignored.
- FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`).
- IDLE: `E0`→EXT; `F0`→BRK; other byte → decode as normal make, stay IDLE.
- EXT: `F0`→EXT_BRK; `E0`→EXT (timer restarts); other byte → decode as extended make →IDLE.
- BRK: `F0`→BRK (timer restarts); `E0`→EXT_BRK; other byte → decode as normal break →IDLE.
- EXT_BRK: `E0`/`F0` → stay, timer restarts; other byte → decode as extended break →IDLE.
- Make of mapped key: `key_held[i]`←1, `key_press[i]` pulses. Break: `key_held[i]`←0, `key_release[i]` pulses, even if already 0.
- Special codes, checked in any state before decoding: `00`/`FF` → `kb_err` pulse, all `key_held` cleared (no release pulses), →IDLE. `AA` (self-test pass) → all `key_held` cleared, →IDLE. `FA`, `FE`, `EE` ignored, state unchanged.
- Timeout: in any non-IDLE state, if no `rx_valid` for `TIMEOUT_CYCLES` cycles → IDLE, no output change.
- `rx_data` is ignored when `rx_valid`=0.

## Timing
- Reset values: `key_held`=0, `key_press`=0, `key_release`=0, `kb_err`=0, FSM=IDLE, timer=0.
- Latency: `rx_valid` at cycle N → outputs updated and pulses high at N+1, low at N+2 unless another byte decodes.
- Back-to-back `rx_valid` every cycle is supported; each byte is processed in its own cycle.
- Timer counts from 0 on entry to a non-IDLE state; timeout fires when the count reaches `TIMEOUT_CYCLES`-1. A byte arriving on the expiry cycle is processed in the prefix state (byte wins).
- Reset asserted mid-sequence clears everything immediately; the next byte is interpreted from IDLE.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined: `key_press[i]` pulses only when `key_held[i]` was 0 (repeated makes from typematic auto-repeat are suppressed); `key_held` is unaffected.
- Not defined: every make of a mapped key pulses `key_press[i]`, including auto-repeats.

## Structure
- Shared package `ps2_key_pkg`: scan-code constants (`E0`, `F0`, `AA`, `FA`, `FE`, `EE`, `00`, `FF`, key codes), key index constants and `NUM_KEYS`=7, FSM state encoding.
- One sub-module: `ps2_prefix_timer` (clear/enable in, expiry pulse out, width `$clog2(TIMEOUT_CYCLES)`).

## Test plan
- Bytes `E0 75` then `E0 F0 75` → `key_held[0]` 1 after 2nd byte, `key_press[0]` pulse once; 0 after 5th byte with `key_release[0]` pulse.
- `5A` then `E0 5A` then `F0 5A` → `key_held[5]`=1, press pulses twice (filter off) / once (filter on); release pulse after `F0 5A`.
- `75` (no prefix) → no output change; `E0` then idle for `TIMEOUT_CYCLES` (override to 16) then `29` → treated as normal make, `key_held[4]`=1.
- Hold up+space, send `FF` → `kb_err` pulse, `key_held`=0, no release pulses; repeat with `AA` → cleared, no `kb_err`.
- Send `E0 F0`, assert `reset` low mid-sequence, release, send `74` → `key_held`=0 (normal `74` unmapped), FSM in IDLE.
- Back-to-back strobes `F0`,`76`,`76` every cycle → release[6] pulse at cycle 2, press[6] at cycle 3, `key_held[6]`=1.
